// File: rtl/mouse_click_ctrl.sv
// Turns the raw left button and the hover flags into single-cycle start/return click commands.
// A command fires only when the debounced press and release both land on the same scene-gated button.
module mouse_click_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOVER_LAT       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mouse_left,
  input  logic       mouse_on_start_button,
  input  logic       mouse_on_return_button,
  input  logic [1:0] scene,
  output logic       start_click,
  output logic       return_click,
  output logic [1:0] btn_highlight,
  output logic       left_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM_START,
    ARM_RETURN,
    WAIT_REL
  } state_t;

  state_t               state, state_n;
  logic [1:0]           scene_latch, scene_latch_n;
  logic                 start_n, return_n;
  logic [HOVER_LAT-1:0] left_sr;
  logic                 left_d;
  logic [CNT_W-1:0]     cnt;
  logic                 settle, rise_evt, fall_evt;
  logic                 tgt_start, tgt_return;

  // Delay the button so it pairs with the block-RAM hover flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_sr <= '0;
    end else begin
      left_sr[0] <= mouse_left;
      for (int i = 1; i < HOVER_LAT; i++) begin
        left_sr[i] <= left_sr[i-1];
      end
    end
  end

  assign left_d   = left_sr[HOVER_LAT-1];
  assign settle   = (left_d != left_level) && (cnt == CNT_MAX);
  assign rise_evt = settle && !left_level;
  assign fall_evt = settle && left_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      left_level <= 1'b0;
    end else if (left_d == left_level) begin
      cnt <= '0;
    end else if (settle) begin
      cnt        <= '0;
      left_level <= !left_level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tgt_start  = (scene == 2'd0) && mouse_on_start_button;
  assign tgt_return = (scene == 2'd2) && mouse_on_return_button;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      scene_latch   <= 2'd0;
      start_click   <= 1'b0;
      return_click  <= 1'b0;
      btn_highlight <= 2'b00;
    end else begin
      state         <= state_n;
      scene_latch   <= scene_latch_n;
      start_click   <= start_n;
      return_click  <= return_n;
      btn_highlight <= {tgt_return, tgt_start};
    end
  end

  // A scene change while armed wins over a release in the same cycle.
  always_comb begin
    state_n       = state;
    scene_latch_n = scene_latch;
    start_n       = 1'b0;
    return_n      = 1'b0;
    case (state)
      IDLE: begin
        if (rise_evt) begin
          scene_latch_n = scene;
          if (tgt_start)       state_n = ARM_START;
          else if (tgt_return) state_n = ARM_RETURN;
          else                 state_n = WAIT_REL;
        end
      end
      ARM_START: begin
        if (scene != scene_latch) begin
          state_n = WAIT_REL;
        end else if (fall_evt) begin
          state_n = IDLE;
          start_n = tgt_start;
        end
      end
      ARM_RETURN: begin
        if (scene != scene_latch) begin
          state_n = WAIT_REL;
        end else if (fall_evt) begin
          state_n  = IDLE;
          return_n = tgt_return;
        end
      end
      WAIT_REL: begin
        if (fall_evt) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mouse_click_ctrl.sv
// Bench for mouse_click_ctrl: directed scenarios plus random button/scene/hover traffic,
// all compared each cycle against a click-level reference model.
module tb_mouse_click_ctrl;

  localparam int D  = 4;
  localparam int HL = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mouse_left;
  logic       hs;
  logic       hr;
  logic [1:0] scene;
  logic       start_click;
  logic       return_click;
  logic [1:0] btn_highlight;
  logic       left_level;

  int vectors     = 0;
  int miscompares = 0;
  int n_start, n_ret, n_lvl;

  bit         raw_q[$];
  bit         ld_hist[$];
  bit         m_level, m_pressed, m_abort;
  int         m_ptgt;
  logic [1:0] m_pscene;
  logic       exp_start, exp_ret;
  logic [1:0] exp_hl;

  mouse_click_ctrl #(.DEBOUNCE_CYCLES(D), .HOVER_LAT(HL)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mouse_left             (mouse_left),
    .mouse_on_start_button  (hs),
    .mouse_on_return_button (hr),
    .scene                  (scene),
    .start_click            (start_click),
    .return_click           (return_click),
    .btn_highlight          (btn_highlight),
    .left_level             (left_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    raw_q.delete();
    ld_hist.delete();
    m_level   = 0;
    m_pressed = 0;
    m_abort   = 0;
    m_ptgt    = 0;
    m_pscene  = 2'd0;
    exp_start = 0;
    exp_ret   = 0;
    exp_hl    = 2'b00;
  endtask

  // Level is accepted once the aligned button has disagreed with it for D sampled cycles in a row.
  task automatic modelStep();
    bit ld, settle, rise, fall;
    int tgt;
    ld = (raw_q.size() >= HL) ? raw_q[raw_q.size() - HL] : 1'b0;
    raw_q.push_back(mouse_left);
    if (raw_q.size() > HL) void'(raw_q.pop_front());
    ld_hist.push_back(ld);
    if (ld_hist.size() > D) void'(ld_hist.pop_front());
    settle = (ld_hist.size() == D);
    foreach (ld_hist[i]) if (ld_hist[i] == m_level) settle = 0;
    rise = settle && !m_level;
    fall = settle && m_level;
    tgt  = (scene == 2'd0 && hs) ? 1 : (scene == 2'd2 && hr) ? 2 : 0;
    exp_start = 0;
    exp_ret   = 0;
    if (m_pressed && m_ptgt != 0 && !m_abort && scene != m_pscene) begin
      m_abort = 1;
      if (fall) begin
        m_ptgt = 0;
        fall   = 0;
      end
    end
    if (rise && !m_pressed) begin
      m_pressed = 1;
      m_ptgt    = tgt;
      m_pscene  = scene;
      m_abort   = 0;
    end else if (fall && m_pressed) begin
      if (!m_abort && m_ptgt != 0 && tgt == m_ptgt) begin
        if (tgt == 1) exp_start = 1;
        else          exp_ret   = 1;
      end
      m_pressed = 0;
    end
    exp_hl = {scene == 2'd2 && hr, scene == 2'd0 && hs};
    if (settle) m_level = !m_level;
  endtask

  task automatic applyStimulus(input logic ml, input logic [1:0] sc, input logic s, input logic r);
    mouse_left = ml;
    scene      = sc;
    hs         = s;
    hr         = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("start_click", start_click, exp_start);
    checkOutput("return_click", return_click, exp_ret);
    checkOutput("btn_highlight", btn_highlight, exp_hl);
    checkOutput("left_level", left_level, m_level);
    n_start += int'(start_click);
    n_ret   += int'(return_click);
    n_lvl   += int'(left_level);
  endtask

  task automatic hold(input int n, input logic ml, input logic [1:0] sc, input logic s, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(ml, sc, s, r);
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_start", start_click, 0);
    checkOutput("rst_return", return_click, 0);
    checkOutput("rst_hl", btn_highlight, 0);
    checkOutput("rst_level", left_level, 0);
    modelReset();
    repeat (n) @(posedge clk);
    #1;
    checkOutput("rst_hold_level", left_level, 0);
    rst_n = 1'b1;
  endtask

  task automatic clearCounts();
    n_start = 0;
    n_ret   = 0;
    n_lvl   = 0;
  endtask

  initial begin
    rst_n      = 1'b1;
    mouse_left = 1'b0;
    scene      = 2'd0;
    hs         = 1'b0;
    hr         = 1'b0;
    clearCounts();
    #2;
    doReset(2);

    // Start click with exact latency points.
    clearCounts();
    hold(4, 1, 2'd0, 1, 0);
    checkOutput("rise_before", left_level, 0);
    hold(1, 1, 2'd0, 1, 0);
    checkOutput("rise_at_k4", left_level, 1);
    hold(5, 1, 2'd0, 1, 0);
    hold(4, 0, 2'd0, 1, 0);
    checkOutput("click_before", start_click, 0);
    hold(1, 0, 2'd0, 1, 0);
    checkOutput("click_at_k4", start_click, 1);
    hold(5, 0, 2'd0, 1, 0);
    checkOutput("start_cnt", n_start, 1);
    checkOutput("start_ret_cnt", n_ret, 0);

    // Glitch rejection.
    clearCounts();
    for (int w = 1; w <= 3; w++) begin
      hold(w, 1, 2'd0, 1, 0);
      hold(5, 0, 2'd0, 1, 0);
    end
    checkOutput("glitch_lvl", n_lvl, 0);
    checkOutput("glitch_start", n_start, 0);
    checkOutput("glitch_ret", n_ret, 0);

    // Off-button press, then a real click.
    clearCounts();
    hold(8, 1, 2'd0, 0, 0);
    hold(3, 1, 2'd0, 1, 0);
    hold(8, 0, 2'd0, 1, 0);
    checkOutput("offbtn_none", n_start, 0);
    hold(8, 1, 2'd0, 1, 0);
    hold(8, 0, 2'd0, 1, 0);
    checkOutput("offbtn_next", n_start, 1);

    // Scene gating.
    clearCounts();
    hold(8, 1, 2'd1, 1, 1);
    checkOutput("game_hl", btn_highlight, 2'b00);
    hold(8, 0, 2'd1, 1, 1);
    checkOutput("game_clicks", n_start + n_ret, 0);
    hold(8, 1, 2'd2, 0, 1);
    checkOutput("over_hl", btn_highlight, 2'b10);
    hold(8, 0, 2'd2, 0, 1);
    checkOutput("over_ret", n_ret, 1);
    checkOutput("over_start", n_start, 0);

    // Scene change while armed, then a normal click still works.
    clearCounts();
    hold(8, 1, 2'd0, 1, 0);
    hold(4, 1, 2'd2, 0, 1);
    hold(8, 0, 2'd2, 0, 1);
    checkOutput("sw_clicks", n_start + n_ret, 0);
    hold(8, 1, 2'd0, 1, 0);
    hold(8, 0, 2'd0, 1, 0);
    checkOutput("sw_after", n_start, 1);

    // Reset while armed with the button held.
    clearCounts();
    hold(8, 1, 2'd0, 1, 0);
    mouse_left = 1'b1;
    doReset(3);
    hold(8, 1, 2'd0, 1, 0);
    hold(8, 0, 2'd0, 1, 0);
    checkOutput("rst_click", n_start, 1);

    // Random traffic with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      logic       ml, s, r;
      logic [1:0] sc;
      int         len;
      ml  = 1'($urandom_range(0, 1));
      sc  = 2'($urandom_range(0, 3));
      s   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) s = !s;
        if ($urandom_range(0, 3) == 0) r = !r;
        if ($urandom_range(0, 15) == 0) sc = 2'($urandom_range(0, 3));
        applyStimulus(ml, sc, s, r);
      end
      if ($urandom_range(0, 59) == 0) doReset(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
